// File: rtl/gtx_frm_pkg.sv
// gtx_frm_pkg -- shared definitions for the GTX/Aurora LocalLink TX framer.
//   * FSM state encoding (2-bit, legacy-compatible localparams)
//   * default payload length (94 x 16-bit words = one 188-byte TS packet)
//   * default header tag byte
//   * debug struct carrying the framer's live FSM/control state
//   * saturating 16-bit increment helper
package gtx_frm_pkg;

  localparam int         PAYLOAD_WORDS_DEF = 94;
  localparam logic [7:0] HDR_TAG_DEF       = 8'hA5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;
  localparam logic [1:0] ST_CKS  = 2'd3;

  // Wide enough for a payload index up to 1023 (PAYLOAD_WORDS <= 1024).
  localparam int PAY_CNT_W = 10;

  // Everything a checker needs to follow the framer: FSM state, payload
  // index within the current frame and the sequence number of the frame.
  typedef struct packed {
    logic [1:0]           state;
    logic [PAY_CNT_W-1:0] pay_cnt;
    logic [7:0]           seq;
  } frm_dbg_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gtx_tx_chksum.sv
// gtx_tx_chksum -- 16-bit additive frame checksum accumulator.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset (sum -> 0)
//   clear     in   restart the sum at 16'h0000 (has priority over add_en)
//   add_en    in   add add_data into the sum this cycle
//   add_data  in   16-bit word to accumulate
//   sum       out  running sum modulo 2^16
module gtx_tx_chksum
  import gtx_frm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        add_en,
  input  logic [15:0] add_data,
  output logic [15:0] sum
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum <= 16'h0000;
    end else if (clear) begin
      sum <= 16'h0000;
    end else if (add_en) begin
      sum <= sum + add_data;
    end
  end

endmodule

// File: rtl/gtx_tx_framer.sv
// gtx_tx_framer -- packs a stream of 16-bit payload words into LocalLink
// frames for an Aurora TX channel:
//   header {HDR_TAG, seq} (sof) | PAYLOAD_WORDS payload words | [checksum] (eof)
// Optional feature macro: GTX_TX_CHKSUM_EN adds a trailing word holding the
// 16-bit sum of the payload; without it the last payload word carries eof.
//
// Ports:
//   clk_156m, rst_156m_n      clock / synchronous active-low reset
//   channel_up                Aurora channel status; dropping it aborts a frame
//   in_data/in_valid/in_ready upstream payload handshake
//   gtx_tx_data/sof_n/eof_n   LocalLink TX word and framing (active low)
//   gtx_tx_src_rdy_n          TX word valid (active low)
//   gtx_tx_dst_rdy_n          Aurora accepts the word (active low)
//   frame_cnt                 completed frames (wrapping)
//   abort_cnt                 aborted frames (saturating)
//
// Handshakes: a word moves across an interface only on a cycle where the
// producer's valid and the consumer's ready are both asserted (in_valid &
// in_ready upstream; !src_rdy_n & !dst_rdy_n downstream). Once presented, a
// TX word and its sof/eof flags never change until it is taken.
module gtx_tx_framer
  import gtx_frm_pkg::*;
#(
  parameter int         PAYLOAD_WORDS = PAYLOAD_WORDS_DEF,
  parameter logic [7:0] HDR_TAG       = HDR_TAG_DEF
)(
  input  logic        clk_156m,
  input  logic        rst_156m_n,
  input  logic        channel_up,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] gtx_tx_data,
  output logic        gtx_tx_sof_n,
  output logic        gtx_tx_eof_n,
  output logic        gtx_tx_src_rdy_n,
  input  logic        gtx_tx_dst_rdy_n,
  output logic [15:0] frame_cnt,
  output logic [15:0] abort_cnt
);

  localparam logic [PAY_CNT_W-1:0] PAY_LAST = PAY_CNT_W'(PAYLOAD_WORDS - 1);

  frm_dbg_t    st;

  // Single registered output slot.
  logic        slot_valid;
  logic        slot_sof;
  logic        slot_eof;
  logic [15:0] slot_data;

  logic        tx_fire;
  logic        slot_free;
  logic        in_fire;
  logic        last_word;
  logic        abort;

  assign tx_fire   = slot_valid & ~gtx_tx_dst_rdy_n;
  // The slot can take a new word if it is empty or its word leaves this cycle.
  assign slot_free = ~slot_valid | tx_fire;
  assign in_ready  = channel_up & (st.state == ST_PAY) & slot_free;
  assign in_fire   = in_valid & in_ready;
  assign last_word = (st.pay_cnt == PAY_LAST);
  assign abort     = (st.state != ST_IDLE) & ~channel_up;

`ifdef GTX_TX_CHKSUM_EN
  localparam bit CHKSUM_ON = 1'b1;
  logic [15:0] cks_sum;

  gtx_tx_chksum u_chksum (
    .clk      (clk_156m),
    .rst_n    (rst_156m_n),
    .clear    (st.state == ST_HDR),
    .add_en   (in_fire),
    .add_data (in_data),
    .sum      (cks_sum)
  );
`else
  localparam bit CHKSUM_ON = 1'b0;
`endif

  assign gtx_tx_data      = slot_data;
  assign gtx_tx_src_rdy_n = ~slot_valid;
  assign gtx_tx_sof_n     = ~(slot_valid & slot_sof);
  assign gtx_tx_eof_n     = ~(slot_valid & slot_eof);

  always_ff @(posedge clk_156m) begin
    if (!rst_156m_n) begin
      st.state   <= ST_IDLE;
      st.pay_cnt <= '0;
      st.seq     <= 8'd0;
      slot_valid <= 1'b0;
      slot_sof   <= 1'b0;
      slot_eof   <= 1'b0;
      slot_data  <= 16'h0000;
      frame_cnt  <= 16'h0000;
      abort_cnt  <= 16'h0000;
    end else begin
      // A frame is complete only when its eof word actually leaves.
      if (tx_fire && slot_eof) begin
        st.seq    <= st.seq + 8'd1;
        frame_cnt <= frame_cnt + 16'd1;
      end

      if (abort) begin
        st.state   <= ST_IDLE;
        st.pay_cnt <= '0;
        slot_valid <= 1'b0;
        slot_sof   <= 1'b0;
        slot_eof   <= 1'b0;
        abort_cnt  <= sat_inc16(abort_cnt);
      end else begin
        case (st.state)
          ST_IDLE: begin
            // The previous frame's last word may still be waiting here.
            if (tx_fire) slot_valid <= 1'b0;
            if (channel_up && in_valid) st.state <= ST_HDR;
          end

          ST_HDR: begin
            st.pay_cnt <= '0;
            // Load only into an empty slot so seq already reflects the
            // previous frame's completion.
            if (!slot_valid) begin
              slot_valid <= 1'b1;
              slot_sof   <= 1'b1;
              slot_eof   <= 1'b0;
              slot_data  <= {HDR_TAG, st.seq};
            end else if (tx_fire) begin
              slot_valid <= 1'b0;
              if (slot_sof) st.state <= ST_PAY;
            end
          end

          ST_PAY: begin
            if (in_fire) begin
              slot_valid <= 1'b1;
              slot_sof   <= 1'b0;
              slot_eof   <= last_word & ~CHKSUM_ON;
              slot_data  <= in_data;
              st.pay_cnt <= last_word ? '0 : st.pay_cnt + 1'b1;
              if (last_word) st.state <= CHKSUM_ON ? ST_CKS : ST_IDLE;
            end else if (tx_fire) begin
              slot_valid <= 1'b0;
            end
          end

          ST_CKS: begin
`ifdef GTX_TX_CHKSUM_EN
            // The last payload word was summed on the edge that entered CKS.
            if (slot_free) begin
              slot_valid <= 1'b1;
              slot_sof   <= 1'b0;
              slot_eof   <= 1'b1;
              slot_data  <= cks_sum;
              st.state   <= ST_IDLE;
            end
`else
            st.state <= ST_IDLE;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gtx_tx_framer.sv
// tb_gtx_tx_framer -- directed bench for gtx_tx_framer. A frame-level model
// turns each payload block into the word list the link must carry; one
// negedge process compares every TX transfer against it and checks that
// stalled words hold. Literal tables pin the model for the key scenarios.
// Works with and without GTX_TX_CHKSUM_EN.
module tb_gtx_tx_framer;

`ifdef GTX_TX_CHKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int PW   = 4;
  localparam int FLEN = PW + 1 + CK;

  // ---------------- clock / reset ----------------
  logic clk_156m   = 1'b0;
  logic rst_156m_n = 1'b0;
  always #3 clk_156m = ~clk_156m;

  logic        channel_up = 1'b0;
  logic [15:0] in_data    = 16'h0;
  logic        in_valid   = 1'b0;
  logic        in_ready;
  logic [15:0] gtx_tx_data;
  logic        gtx_tx_sof_n, gtx_tx_eof_n, gtx_tx_src_rdy_n;
  logic        gtx_tx_dst_rdy_n = 1'b0;
  logic        dst_toggle       = 1'b0;
  logic [15:0] frame_cnt, abort_cnt;

  logic [15:0] in2_data  = 16'h0;
  logic        in2_valid = 1'b0;
  logic        in2_ready;
  logic [15:0] tx2_data;
  logic        tx2_sof_n, tx2_eof_n, tx2_src_rdy_n;
  logic [15:0] frame2_cnt, abort2_cnt;

  gtx_tx_framer #(.PAYLOAD_WORDS(PW), .HDR_TAG(8'hA5)) dut (
    .clk_156m(clk_156m), .rst_156m_n(rst_156m_n), .channel_up(channel_up),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .gtx_tx_data(gtx_tx_data), .gtx_tx_sof_n(gtx_tx_sof_n),
    .gtx_tx_eof_n(gtx_tx_eof_n), .gtx_tx_src_rdy_n(gtx_tx_src_rdy_n),
    .gtx_tx_dst_rdy_n(gtx_tx_dst_rdy_n),
    .frame_cnt(frame_cnt), .abort_cnt(abort_cnt)
  );

  gtx_tx_framer #(.PAYLOAD_WORDS(2), .HDR_TAG(8'hA5)) dut2 (
    .clk_156m(clk_156m), .rst_156m_n(rst_156m_n), .channel_up(channel_up),
    .in_data(in2_data), .in_valid(in2_valid), .in_ready(in2_ready),
    .gtx_tx_data(tx2_data), .gtx_tx_sof_n(tx2_sof_n),
    .gtx_tx_eof_n(tx2_eof_n), .gtx_tx_src_rdy_n(tx2_src_rdy_n),
    .gtx_tx_dst_rdy_n(1'b0),
    .frame_cnt(frame2_cnt), .abort_cnt(abort2_cnt)
  );

  // Downstream ready: always ready, or toggling every cycle.
  always @(posedge clk_156m) begin
    #1;
    if (dst_toggle) gtx_tx_dst_rdy_n = ~gtx_tx_dst_rdy_n;
    else            gtx_tx_dst_rdy_n = 1'b0;
  end

  // ---------------- scoreboard state ----------------
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [17:0] exp_q[$];   // {data, sof, eof}, flags active high
  logic [17:0] got_q[$];
  logic [17:0] got2_q[$];
  logic [15:0] pay_buf[PW];
  logic [7:0]  m_seq;
  int          m_frames, m_aborts;
  int          bubble_cnt = 0, sof_cnt = 0, wif = 0, hold_cnt = 0;
  logic [15:0] last_hdr;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_word, cur, exp_w;
  logic [17:0] lit1[6];
  logic [17:0] lit2[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk_156m) begin
    if (!rst_156m_n) begin
      prev_stall = 1'b0;
      wif = 0;
    end else begin
      cur = {gtx_tx_data, ~gtx_tx_sof_n, ~gtx_tx_eof_n};
      if (!gtx_tx_src_rdy_n) begin
        if (prev_stall) begin
          hold_cnt++;
          check("hold_stable", 32'(cur), 32'(prev_word));
        end
        check("sof_eof_same_word", 32'(cur[1] & cur[0]), 32'd0);
        if (!gtx_tx_dst_rdy_n) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            $display("FAIL tx_word: actual=%h/%b%b required=none", cur[17:2], cur[1], cur[0]);
          end else begin
            exp_w = exp_q.pop_front();
            if (cur === exp_w) n_pass++;
            else $display("FAIL tx_word: actual=%h sof=%b eof=%b required=%h sof=%b eof=%b",
                          cur[17:2], cur[1], cur[0], exp_w[17:2], exp_w[1], exp_w[0]);
          end
          got_q.push_back(cur);
          if (cur[1]) begin
            sof_cnt++;
            last_hdr = cur[17:2];
            wif = 1;
          end else if (wif > 0) begin
            wif++;
          end
          if (cur[0]) wif = 0;
        end
      end else if (wif >= 2) begin
        bubble_cnt++;
      end
      prev_stall = !gtx_tx_src_rdy_n && gtx_tx_dst_rdy_n;
      prev_word  = cur;
    end
  end

  always @(negedge clk_156m)
    if (rst_156m_n && !tx2_src_rdy_n) got2_q.push_back({tx2_data, ~tx2_sof_n, ~tx2_eof_n});

  // ---------------- model ----------------
  // Word list of one frame built straight from the framing rules.
  task automatic expect_frame();
    logic [15:0] sum;
    sum = 16'h0000;
    exp_q.push_back({8'hA5, m_seq, 2'b10});
    for (int i = 0; i < PW; i++) begin
      exp_q.push_back({pay_buf[i], 1'b0, (i == PW - 1) && (CK == 0)});
      sum = sum + pay_buf[i];
    end
    if (CK != 0) exp_q.push_back({sum, 2'b01});
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_156m_n = 1'b0;
    in_valid   = 1'b0;
    in2_valid  = 1'b0;
    channel_up = 1'b1;
    dst_toggle = 1'b0;
    repeat (3) @(posedge clk_156m);
    #1;
    rst_156m_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    got2_q.delete();
    m_seq = 8'd0; m_frames = 0; m_aborts = 0;
  endtask

  task automatic send_word(input logic [15:0] d);
    int t;
    bit done;
    t = 0; done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!done && t < 100) begin
      @(negedge clk_156m);
      done = in_ready;
      @(posedge clk_156m);
      #1;
      t++;
    end
    check("in_accept", 32'(done), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_word2(input logic [15:0] d);
    int t;
    bit done;
    t = 0; done = 1'b0;
    in2_valid = 1'b1;
    in2_data  = d;
    while (!done && t < 100) begin
      @(negedge clk_156m);
      done = in2_ready;
      @(posedge clk_156m);
      #1;
      t++;
    end
    check("in2_accept", 32'(done), 32'd1);
    in2_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (t < 100) begin
      @(negedge clk_156m);
      if (exp_q.size() == 0 && gtx_tx_src_rdy_n) break;
      t++;
    end
    check("drain", 32'(t < 100), 32'd1);
    @(posedge clk_156m);
    #1;
  endtask

  task automatic do_abort();
    channel_up = 1'b0;
    @(negedge clk_156m);
    @(posedge clk_156m);
    #1;
    exp_q.delete();
    m_aborts++;
    @(negedge clk_156m);
    check("abort_src_rdy_n", 32'(gtx_tx_src_rdy_n), 32'd1);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk_156m);
    #1;
    channel_up = 1'b1;
  endtask

  task automatic run_frame(input int drop_at, input int gap_at);
    expect_frame();
    for (int i = 0; i < PW; i++) begin
      if (i == drop_at) begin
        do_abort();
        return;
      end
      if (i == gap_at) begin
        repeat (3) @(posedge clk_156m);
        #1;
      end
      send_word(pay_buf[i]);
    end
    wait_drain();
    m_seq++;
    m_frames++;
  endtask

  task automatic check_counters();
    check("frame_cnt_model", 32'(frame_cnt), 32'(m_frames));
    check("abort_cnt_model", 32'(abort_cnt), 32'(m_aborts));
  endtask

  task automatic check_lit1(input string name);
    check({name, "_len"}, 32'(got_q.size()), 32'(FLEN));
    for (int i = 0; i < FLEN; i++) check(name, 32'(got_q[i]), 32'(lit1[i]));
  endtask

  // Hard stop in case something never finishes.
  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    lit1[0] = {16'hA500, 2'b10};
    lit1[1] = {16'h0001, 2'b00};
    lit1[2] = {16'h0002, 2'b00};
    lit1[3] = {16'h0003, 2'b00};
    lit1[4] = {16'h0004, 1'b0, CK == 0};
    lit1[5] = {16'h000A, 2'b01};
    lit2[0] = {16'hA500, 2'b10};
    lit2[1] = {16'hFFFF, 2'b00};
    lit2[2] = {16'h0001, 1'b0, CK == 0};
    lit2[3] = {16'h0000, 2'b01};

    // Reset state
    do_reset();
    @(negedge clk_156m);
    check("rst_src_rdy_n", 32'(gtx_tx_src_rdy_n), 32'd1);
    check("rst_sof_n", 32'(gtx_tx_sof_n), 32'd1);
    check("rst_eof_n", 32'(gtx_tx_eof_n), 32'd1);
    check("rst_data", 32'(gtx_tx_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_abort_cnt", 32'(abort_cnt), 32'd0);
    @(posedge clk_156m);
    #1;

    // 1: back-to-back 1,2,3,4
    for (int k = 0; k < PW; k++) pay_buf[k] = 16'(k + 1);
    run_frame(-1, -1);
    check_lit1("s1_word");
    check("s1_frame_cnt", 32'(frame_cnt), 32'd1);
    check_counters();

    // 2: same data, dst_rdy_n toggling
    do_reset();
    dst_toggle = 1'b1;
    hold_cnt = 0;
    run_frame(-1, -1);
    dst_toggle = 1'b0;
    check_lit1("s2_word");
    check("s2_stalls_seen", 32'(hold_cnt > 0), 32'd1);
    check_counters();

    // 3: channel drop after two payload words, then a clean frame
    do_reset();
    run_frame(2, -1);
    check("s3_abort_cnt", 32'(abort_cnt), 32'd1);
    check("s3_frame_cnt", 32'(frame_cnt), 32'd0);
    got_q.delete();
    run_frame(-1, -1);
    check("s3_next_hdr", 32'(got_q[0]), 32'({16'hA500, 2'b10}));
    check("s3_frame_cnt_after", 32'(frame_cnt), 32'd1);
    check_counters();

    // 4: 256 frames, seq wraps
    do_reset();
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < PW; k++) pay_buf[k] = 16'(f * 4 + k);
      got_q.delete();
      run_frame(-1, -1);
      if (f == 255) check("s4_hdr_255", 32'(last_hdr), 32'h0000A5FF);
    end
    check("s4_frame_cnt_256", 32'(frame_cnt), 32'd256);
    got_q.delete();
    run_frame(-1, -1);
    check("s4_hdr_257", 32'(got_q[0]), 32'({16'hA500, 2'b10}));
    check_counters();

    // 5: 3-cycle in_valid gap mid-payload
    do_reset();
    pay_buf[0] = 16'h1111; pay_buf[1] = 16'h2222;
    pay_buf[2] = 16'h3333; pay_buf[3] = 16'hF000;
    bubble_cnt = 0;
    sof_cnt = 0;
    run_frame(-1, 2);
    check("s5_bubbles", 32'(bubble_cnt), 32'd3);
    check("s5_single_frame", 32'(sof_cnt), 32'd1);
    check("s5_len", 32'(got_q.size()), 32'(FLEN));
    check("s5_last_word", 32'(got_q[FLEN-1][17:2]), (CK != 0) ? 32'h5666 : 32'hF000);
    check_counters();

    // 6: reset mid-frame discards without counting an abort
    do_reset();
    expect_frame();
    send_word(pay_buf[0]);
    send_word(pay_buf[1]);
    do_reset();
    @(negedge clk_156m);
    check("s6_abort_cnt", 32'(abort_cnt), 32'd0);
    check("s6_frame_cnt", 32'(frame_cnt), 32'd0);
    check("s6_src_rdy_n", 32'(gtx_tx_src_rdy_n), 32'd1);
    @(posedge clk_156m);
    #1;

    // 7: two-word payload FFFF, 0001 on the second instance
    send_word2(16'hFFFF);
    send_word2(16'h0001);
    repeat (10) @(posedge clk_156m);
    #1;
    check("s7_len", 32'(got2_q.size()), 32'(3 + CK));
    for (int i = 0; i < 3 + CK; i++) check("s7_word", 32'(got2_q[i]), 32'(lit2[i]));
    check("s7_frame_cnt", 32'(frame2_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
